ball_bounce_resolver: RTL
=========================

Name: ball_bounce_resolver

Overview:
- Sits directly downstream of the ball/brick/paddle collision detector and upstream of the ball motion block.
- Consumes the same per-pixel drawing requests plus the current pixel and object coordinates.
- Over one frame it classifies every collision pixel by collision source and by the side of the ball that was hit.
- At the next startOfFrame it issues one registered set of bounce commands (flip X, flip Y, paddle zone, brick-hit pulses), then optionally blocks further bounces for a cooldown.

Parameters:
- BALL_SIZE, 16, ball sprite width and height in pixels; must be a power of two and at least 4.
- EDGE, 4, depth in pixels of each ball edge band used for side classification; must be less than BALL_SIZE/2.
- PADDLE_W_LOG2, 6, log2 of the paddle width in pixels; must be at least 3.
- COOLDOWN_FRAMES, 2, number of whole frames after a bounce in which all collisions are ignored; 0 disables cooldown.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous reset, active-high.
- startOfFrame, in, 1, one-cycle pulse at the start of each frame.
- pixelX, in, 11, current scan X coordinate.
- pixelY, in, 11, current scan Y coordinate.
- ballTopLeftX, in, 11, ball sprite origin X.
- ballTopLeftY, in, 11, ball sprite origin Y.
- paddleTopLeftX, in, 11, paddle origin X.
- ballMovingDown, in, 1, 1 when the ball's Y velocity is positive (moving down).
- drawing_request_Ball, in, 1, ball pixel active.
- drawing_request_1, in, 1, brick group 1 pixel active.
- drawing_request_2, in, 1, brick group 2 pixel active.
- PaddleDrawingRequest, in, 1, paddle pixel active.
- bounceX, out, 1, one-cycle pulse: negate ball X velocity.
- bounceY, out, 1, one-cycle pulse: negate ball Y velocity.
- paddleZone, out, 3, paddle hit zone (0 = leftmost, 7 = rightmost); valid while bounceY=1 and paddleHit=1.
- paddleHit, out, 1, one-cycle pulse: the bounce was caused by the paddle.
- brickHit1, out, 1, one-cycle pulse: brick group 1 was hit this frame.
- brickHit2, out, 1, one-cycle pulse: brick group 2 was hit this frame.

Behaviour:
- Reset:
  - All outputs 0.
  - All accumulated flags cleared.
  - State COLLECT, cooldown counter 0.
  - Reset has priority over every other event, including a reset arriving mid-frame or mid-cooldown.
- States: COLLECT, EVAL, COOLDOWN.
- Collision pixel definitions:
  - Collision pixel = drawing_request_Ball AND (drawing_request_1 OR drawing_request_2 OR PaddleDrawingRequest).
  - Offsets dx = pixelX - ballTopLeftX and dy = pixelY - ballTopLeftY, taken as unsigned 11-bit values.
  - A pixel with dx or dy at or above BALL_SIZE is discarded.
- COLLECT: on each collision pixel, sticky-set the following flags:
  - hitTop if dy < EDGE.
  - hitBot if dy >= BALL_SIZE - EDGE.
  - hitLeft if dx < EDGE.
  - hitRight if dx >= BALL_SIZE - EDGE.
  - src1 if drawing_request_1, src2 if drawing_request_2.
  - srcPad if PaddleDrawingRequest and ballMovingDown. A paddle pixel while the ball moves up is ignored.
  - On the first paddle collision pixel of the frame only, latch zone = (pixelX - paddleTopLeftX) >> (PADDLE_W_LOG2-3), saturated to 7. A negative difference gives 0.
- startOfFrame in COLLECT: go to EVAL. The flags are snapshotted into EVAL registers, and the live flags are cleared in the same cycle. A collision pixel on the startOfFrame cycle counts toward the new frame.
- EVAL: lasts exactly one cycle and registers the outputs, which are visible on the cycle after EVAL (latency 2 clocks from startOfFrame).
  - bounceY = srcPad OR (brick AND (hitTop XOR hitBot)), where brick = src1 OR src2.
  - bounceX = brick AND NOT srcPad AND (hitLeft XOR hitRight).
  - Brick hit with no decisive axis (both XORs 0): bounceX = bounceY = 1.
  - paddleHit = srcPad; paddleZone = the latched zone when srcPad = 1, else 0.
  - brickHit1 = src1, brickHit2 = src2.
  - Next state: COOLDOWN if any bounce was issued and COOLDOWN_FRAMES > 0, else COLLECT.
- COOLDOWN:
  - All collision pixels are ignored.
  - The counter loads COOLDOWN_FRAMES and decrements on each startOfFrame.
  - On the startOfFrame that takes the counter to 0, go to COLLECT; that cycle's pixel is collected.
- Output pulses are exactly one clock wide, with at most one set per frame.

Decomposition:
- Shared package (e.g. game_pkg) holds the state enum type, the 11-bit coordinate typedef, and BALL_SIZE and EDGE defaults, shared with the ball motion block.
- One natural sub-module, ball_hit_classifier: a purely combinational block taking dx, dy and the drawing requests, producing per-pixel side and source flags.

Test Plan:
- Reset: drive reset high for 2 cycles mid-frame with flags set -> all outputs 0, no pulse at the next startOfFrame.
- Brick bottom hit: ball at (100,200), brick1 overlaps pixels with dy = 14..15, dx = 6..9 -> 2 cycles after startOfFrame, bounceY=1, bounceX=0, brickHit1=1 for one cycle.
- Brick side hit: brick2 overlaps dx = 0..1, dy = 6..9 -> bounceX=1, bounceY=0, brickHit2=1.
- Paddle hits:
  - With paddleTopLeftX=300 and a first collision at pixelX=340, ballMovingDown=1 -> bounceY=1, paddleHit=1, paddleZone=5.
  - The same stimulus with ballMovingDown=0 -> no pulses.
- Cooldown: a bounce in frame N followed by collisions in frames N+1 and N+2 -> no pulses; a collision in frame N+3 -> pulse issued.
- Boundary: a collision pixel coinciding with startOfFrame -> counted in the new frame only; pixels with dx = 16 -> discarded.

Source files
------------

// File: rtl/ball_bounce_resolver_pkg.sv
// Shared types for the ball/brick/paddle game datapath.
//   coord_t     : 11-bit screen coordinate
//   state_t     : bounce resolver control states
//   hit_flags_t : per-pixel / per-frame side and source flags
//   BALL_SIZE_DEF, EDGE_DEF : defaults shared with the ball motion block
package ball_bounce_resolver_pkg;

  typedef logic [10:0] coord_t;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    EVAL     = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  typedef struct packed {
    logic top;
    logic bot;
    logic left;
    logic right;
    logic src1;
    logic src2;
    logic pad;
  } hit_flags_t;

  localparam int BALL_SIZE_DEF = 16;
  localparam int EDGE_DEF      = 4;

endpackage

// File: rtl/ball_hit_classifier.sv
// Combinational per-pixel collision classifier.
// Inputs : dx, dy       - pixel offset inside the ball sprite (unsigned, wraps)
//          ball_req     - ball pixel active
//          req1, req2   - brick group pixels active
//          pad_req      - paddle pixel active
//          moving_down  - ball Y velocity positive
// Outputs: hit          - pixel is a valid collision inside the ball box
//          flags        - side/source flags for this pixel (all 0 when !hit)
module ball_hit_classifier
  import ball_bounce_resolver_pkg::*;
#(
  parameter int BALL_SIZE = BALL_SIZE_DEF,
  parameter int EDGE      = EDGE_DEF
) (
  input  coord_t     dx,
  input  coord_t     dy,
  input  logic       ball_req,
  input  logic       req1,
  input  logic       req2,
  input  logic       pad_req,
  input  logic       moving_down,
  output logic       hit,
  output hit_flags_t flags
);

  localparam coord_t SIZE = coord_t'(BALL_SIZE);
  localparam coord_t LO   = coord_t'(EDGE);
  localparam coord_t HI   = coord_t'(BALL_SIZE - EDGE);

  logic pad_ok;
  logic in_box;

  // A paddle pixel only matters while the ball is descending onto it.
  assign pad_ok = pad_req & moving_down;
  assign in_box = (dx < SIZE) && (dy < SIZE);
  assign hit    = ball_req & (req1 | req2 | pad_ok) & in_box;

  always_comb begin
    flags = '0;
    if (hit) begin
      flags.top   = (dy < LO);
      flags.bot   = (dy >= HI);
      flags.left  = (dx < LO);
      flags.right = (dx >= HI);
      flags.src1  = req1;
      flags.src2  = req2;
      flags.pad   = pad_ok;
    end
  end

endmodule

// File: rtl/ball_bounce_resolver.sv
// Frame-based bounce resolver.
// Collects collision pixels over a frame, then at the next startOfFrame
// issues one registered set of bounce pulses (2 clocks after startOfFrame),
// optionally followed by a cooldown of COOLDOWN_FRAMES whole frames.
// Inputs : clk, reset (sync, active-high), startOfFrame, pixelX/Y,
//          ballTopLeftX/Y, paddleTopLeftX, ballMovingDown, drawing requests
// Outputs: bounceX, bounceY, paddleZone, paddleHit, brickHit1, brickHit2
module ball_bounce_resolver
  import ball_bounce_resolver_pkg::*;
#(
  parameter int BALL_SIZE       = BALL_SIZE_DEF,
  parameter int EDGE            = EDGE_DEF,
  parameter int PADDLE_W_LOG2   = 6,
  parameter int COOLDOWN_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [10:0] ballTopLeftX,
  input  logic [10:0] ballTopLeftY,
  input  logic [10:0] paddleTopLeftX,
  input  logic        ballMovingDown,
  input  logic        drawing_request_Ball,
  input  logic        drawing_request_1,
  input  logic        drawing_request_2,
  input  logic        PaddleDrawingRequest,
  output logic        bounceX,
  output logic        bounceY,
  output logic [2:0]  paddleZone,
  output logic        paddleHit,
  output logic        brickHit1,
  output logic        brickHit2
);

  localparam int ZSHIFT = PADDLE_W_LOG2 - 3;
  localparam int CNT_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  // Zone = offset into the paddle in eighths, clamped to 0..7.
  function automatic logic [2:0] sat_zone(input coord_t px, input coord_t padx);
    logic signed [11:0] diff;
    logic [11:0]        mag;
    logic [11:0]        sh;
    diff = $signed({1'b0, px}) - $signed({1'b0, padx});
    mag  = diff;
    sh   = mag >> ZSHIFT;
    if (diff < 0)        return 3'd0;
    else if (sh > 12'd7) return 3'd7;
    else                 return sh[2:0];
  endfunction

  coord_t     dx, dy;
  logic       pix_hit;
  hit_flags_t pix;
  logic [2:0] pix_zone;

  assign dx       = pixelX - ballTopLeftX;
  assign dy       = pixelY - ballTopLeftY;
  assign pix_zone = sat_zone(pixelX, paddleTopLeftX);

  ball_hit_classifier #(
    .BALL_SIZE(BALL_SIZE),
    .EDGE     (EDGE)
  ) u_cls (
    .dx         (dx),
    .dy         (dy),
    .ball_req   (drawing_request_Ball),
    .req1       (drawing_request_1),
    .req2       (drawing_request_2),
    .pad_req    (PaddleDrawingRequest),
    .moving_down(ballMovingDown),
    .hit        (pix_hit),
    .flags      (pix)
  );

  state_t             state, state_n;
  hit_flags_t         live_p0, live_n;
  logic               zvld_p0, zvld_n;
  logic [2:0]         zone_p0, zone_n;
  hit_flags_t         snap_p1, snap_n;
  logic [2:0]         zsnap_p1, zsnap_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               bx_n, by_n, ph_n, b1_n, b2_n;
  logic [2:0]         pz_n;

  hit_flags_t acc;
  logic       acc_zvld;
  logic [2:0] acc_zone;
  logic       brick, yaxis, xaxis, no_axis;

  // Sticky accumulation of this cycle's pixel into the live frame flags;
  // only the first qualifying paddle pixel of the frame sets the zone.
  always_comb begin
    acc      = live_p0 | pix;
    acc_zvld = zvld_p0 | pix.pad;
    acc_zone = (pix.pad && !zvld_p0) ? pix_zone : zone_p0;
  end

  assign brick   = snap_p1.src1 | snap_p1.src2;
  assign yaxis   = snap_p1.top ^ snap_p1.bot;
  assign xaxis   = snap_p1.left ^ snap_p1.right;
  assign no_axis = brick & ~snap_p1.pad & ~yaxis & ~xaxis;

  always_comb begin
    state_n  = state;
    live_n   = live_p0;
    zvld_n   = zvld_p0;
    zone_n   = zone_p0;
    snap_n   = snap_p1;
    zsnap_n  = zsnap_p1;
    cnt_n    = cnt;
    bx_n     = 1'b0;
    by_n     = 1'b0;
    ph_n     = 1'b0;
    pz_n     = 3'd0;
    b1_n     = 1'b0;
    b2_n     = 1'b0;
    case (state)
      COLLECT: begin
        if (startOfFrame) begin
          // Close the frame; the pixel on this cycle opens the new one.
          snap_n  = live_p0;
          zsnap_n = zone_p0;
          live_n  = pix;
          zvld_n  = pix.pad;
          zone_n  = pix.pad ? pix_zone : 3'd0;
          state_n = EVAL;
        end else begin
          live_n = acc;
          zvld_n = acc_zvld;
          zone_n = acc_zone;
        end
      end
      EVAL: begin
        live_n = acc;
        zvld_n = acc_zvld;
        zone_n = acc_zone;
        by_n   = snap_p1.pad | (brick & yaxis) | no_axis;
        bx_n   = (brick & ~snap_p1.pad & xaxis) | no_axis;
        ph_n   = snap_p1.pad;
        pz_n   = snap_p1.pad ? zsnap_p1 : 3'd0;
        b1_n   = snap_p1.src1;
        b2_n   = snap_p1.src2;
        if ((COOLDOWN_FRAMES > 0) && (by_n || bx_n)) begin
          state_n = COOLDOWN;
          cnt_n   = CNT_W'(COOLDOWN_FRAMES);
        end else begin
          state_n = COLLECT;
        end
      end
      COOLDOWN: begin
        live_n = '0;
        zvld_n = 1'b0;
        zone_n = 3'd0;
        if (startOfFrame) begin
          cnt_n = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_n = COLLECT;
            live_n  = pix;
            zvld_n  = pix.pad;
            zone_n  = pix.pad ? pix_zone : 3'd0;
          end
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  // p0: live frame flags | p1: end-of-frame snapshot | outputs: bounce pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= COLLECT;
      live_p0    <= '0;
      zvld_p0    <= 1'b0;
      zone_p0    <= 3'd0;
      snap_p1    <= '0;
      zsnap_p1   <= 3'd0;
      cnt        <= '0;
      bounceX    <= 1'b0;
      bounceY    <= 1'b0;
      paddleHit  <= 1'b0;
      paddleZone <= 3'd0;
      brickHit1  <= 1'b0;
      brickHit2  <= 1'b0;
    end else begin
      state      <= state_n;
      live_p0    <= live_n;
      zvld_p0    <= zvld_n;
      zone_p0    <= zone_n;
      snap_p1    <= snap_n;
      zsnap_p1   <= zsnap_n;
      cnt        <= cnt_n;
      bounceX    <= bx_n;
      bounceY    <= by_n;
      paddleHit  <= ph_n;
      paddleZone <= pz_n;
      brickHit1  <= b1_n;
      brickHit2  <= b2_n;
    end
  end

endmodule
